// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared constants and FSM encoding for the scoreboarded register file
package regfile_sb_pkg;

   localparam logic RST_ENABLE   = 1'b0;
   localparam logic WRITE_ENABLE = 1'b1;
   localparam logic READ_ENABLE  = 1'b1;

   typedef enum logic {
      SB_CLEAR = 1'b0,
      SB_READY = 1'b1
   } sb_state_e;

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - write, issue and read bundle between pipeline stages and the register file
interface regfile_sb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
);
   localparam int AW = $clog2(NREG);

   logic                 init_done;
   logic                 wa_en;
   logic [AW-1:0]        wa_addr;
   logic [XLEN-1:0]      wa_data;
   logic                 wb_en;
   logic [AW-1:0]        wb_addr;
   logic [XLEN-1:0]      wb_data;
   logic                 iss_en;
   logic [AW-1:0]        iss_addr;
   logic [NRD-1:0]       rd_en;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*XLEN-1:0]  rd_data;
   logic [NRD-1:0]       rd_busy;

   modport master (
      input  init_done, rd_data, rd_busy,
      output wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
             iss_en, iss_addr, rd_en, rd_addr
   );

   modport slave (
      output init_done, rd_data, rd_busy,
      input  wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
             iss_en, iss_addr, rd_en, rd_addr
   );

endinterface

// File: rtl/regfile_fwd.sv
// rtl/regfile_fwd.sv - one read port: write-port forwarding mux and busy qualification
module regfile_fwd #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            ready,
   input  logic            en,
   input  logic [AW-1:0]   addr,
   input  logic            wa_en,
   input  logic [AW-1:0]   wa_addr,
   input  logic [XLEN-1:0] wa_data,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic [XLEN-1:0] arr_data,
   input  logic            busy_bit,
   output logic [XLEN-1:0] data,
   output logic            busy
);

   logic hit_a;
   logic hit_b;
   logic live;

   always_comb begin
      hit_a = wa_en && (wa_addr == addr);
      hit_b = wb_en && (wb_addr == addr);
      live  = ready && en && (addr != '0);
      data  = '0;
      if (live) begin
         if (hit_a)      data = wa_data;
         else if (hit_b) data = wb_data;
         else            data = arr_data;
      end
      // a value arriving this cycle is forwarded, so the reader need not stall
      busy = live && busy_bit && !hit_a && !hit_b;
   end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - dual-write register file with forwarding, busy scoreboard and post-reset clear engine
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
) (
   input  logic        clk,
   input  logic        rst,
   regfile_sb_if.slave bus
);
   localparam int AW = $clog2(NREG);

   sb_state_e       state_q;
   sb_state_e       state_d;
   logic [AW-1:0]   idx_q;
   logic            ready;
   logic            wb_wins;
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) state_q <= SB_CLEAR;
      else                   state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == SB_CLEAR && idx_q == AW'(NREG - 1)) state_d = SB_READY;
   end

   always_comb begin
      ready = (state_q == SB_READY);
   end

   assign bus.init_done = ready;

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE)      idx_q <= '0;
      else if (state_q == SB_CLEAR) idx_q <= idx_q + 1'b1;
   end

   assign wb_wins = bus.wb_en && !(bus.wa_en && bus.wa_addr == bus.wb_addr);

   // The array carries no reset; the clear engine zeroes one entry per cycle instead.
   always_ff @(posedge clk) begin
      if (!ready) begin
         regs[idx_q] <= '0;
      end else begin
         if (bus.wa_en == WRITE_ENABLE && bus.wa_addr != '0) regs[bus.wa_addr] <= bus.wa_data;
         if (wb_wins && bus.wb_addr != '0)                   regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   // Issue is applied after the clears so a new producer keeps the register busy.
   always_comb begin
      busy_d = busy_q;
      if (bus.wa_en)  busy_d[bus.wa_addr]  = 1'b0;
      if (bus.wb_en)  busy_d[bus.wb_addr]  = 1'b0;
      if (bus.iss_en) busy_d[bus.iss_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) busy_q <= '0;
      else if (ready)        busy_q <= busy_d;
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = bus.rd_addr[g*AW +: AW];

      regfile_fwd #(.XLEN(XLEN), .AW(AW)) u_fwd (
         .ready    (ready),
         .en       (bus.rd_en[g] == READ_ENABLE),
         .addr     (addr),
         .wa_en    (bus.wa_en),
         .wa_addr  (bus.wa_addr),
         .wa_data  (bus.wa_data),
         .wb_en    (bus.wb_en),
         .wb_addr  (bus.wb_addr),
         .wb_data  (bus.wb_data),
         .arr_data (regs[addr]),
         .busy_bit (busy_q[addr]),
         .data     (bus.rd_data[g*XLEN +: XLEN]),
         .busy     (bus.rd_busy[g])
      );
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed scoreboard bench for regfile_sb at default and wide/shallow parameters
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;
   int   checks = 0;
   int   errors = 0;
   logic [63:0] exp_q [$];
   logic [63:0] vals [6];

   regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus_a ();
   regfile_sb_if #(.XLEN(64), .NREG(16), .NRD(4)) bus_b ();

   regfile_sb #(.XLEN(32), .NREG(32), .NRD(2)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
   regfile_sb #(.XLEN(64), .NREG(16), .NRD(4)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [63:0] v);
      exp_q.push_back(v);
   endtask

   task automatic pop_chk(input string tag, input logic [63:0] obs);
      logic [63:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=%0h expected=none_queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         chk(tag, obs, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_a();
      bus_a.wa_en = 1'b0; bus_a.wa_addr = '0; bus_a.wa_data = '0;
      bus_a.wb_en = 1'b0; bus_a.wb_addr = '0; bus_a.wb_data = '0;
      bus_a.iss_en = 1'b0; bus_a.iss_addr = '0;
   endtask

   task automatic idle_b();
      bus_b.wa_en = 1'b0; bus_b.wa_addr = '0; bus_b.wa_data = '0;
      bus_b.wb_en = 1'b0; bus_b.wb_addr = '0; bus_b.wb_data = '0;
      bus_b.iss_en = 1'b0; bus_b.iss_addr = '0;
      bus_b.rd_en = '0; bus_b.rd_addr = '0;
   endtask

   task automatic rd_set_a(input int p, input logic [4:0] a);
      bus_a.rd_en[p] = 1'b1;
      bus_a.rd_addr[p*5 +: 5] = a;
   endtask

   task automatic rd_set_b(input int p, input logic [3:0] a);
      bus_b.rd_en[p] = 1'b1;
      bus_b.rd_addr[p*4 +: 4] = a;
   endtask

   function automatic logic [63:0] rd_a(input int p);
      return 64'(bus_a.rd_data[p*32 +: 32]);
   endfunction

   function automatic logic [63:0] rd_b(input int p);
      return bus_b.rd_data[p*64 +: 64];
   endfunction

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      idle_a();
      idle_b();
      bus_a.rd_en = '0;
      bus_a.rd_addr = '0;
      vals[0] = 64'h0;
      vals[1] = 64'h1111_0000_0000_0001;
      vals[2] = 64'h2222_0000_0000_0002;
      vals[3] = 64'h3333_0000_0000_0003;
      vals[4] = 64'h4444_0000_0000_0004;
      vals[5] = 64'hDEAD_BEEF_CAFE_F00D;
      repeat (2) tick();

      rd_set_a(0, 5'd5);
      rd_set_a(1, 5'd9);
      settle();
      chk("rst_init_done", 64'(bus_a.init_done), 64'h0);
      chk("rst_busy", 64'(bus_a.rd_busy), 64'h0);
      push(64'h0); pop_chk("rst_rd0", rd_a(0));
      push(64'h0); pop_chk("rst_rd1", rd_a(1));
      chk("rstb_init_done", 64'(bus_b.init_done), 64'h0);

      // clear sequence, NREG=32; write/issue attempts during CLEAR must be ignored
      rst_a = 1'b1;
      for (int cyc = 1; cyc <= 32; cyc++) begin
         tick();
         if (cyc == 9) begin
            bus_a.wa_en = 1'b1; bus_a.wa_addr = 5'd5; bus_a.wa_data = 32'hAAAA;
            bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd6;
         end
         if (cyc == 10) idle_a();
         settle();
         chk($sformatf("clear_init_done_c%0d", cyc), 64'(bus_a.init_done), (cyc >= 32) ? 64'h1 : 64'h0);
         if (cyc == 9) begin
            push(64'h0); pop_chk("clear_rd_masked", rd_a(0));
            chk("clear_busy_masked", 64'(bus_a.rd_busy), 64'h0);
         end
      end

      for (int i = 0; i < 32; i++) begin
         rd_set_a(0, 5'(i));
         rd_set_a(1, 5'(31 - i));
         settle();
         push(64'h0); pop_chk($sformatf("init_rd0_x%0d", i), rd_a(0));
         push(64'h0); pop_chk($sformatf("init_rd1_x%0d", 31 - i), rd_a(1));
      end
      rd_set_a(0, 5'd6);
      settle();
      chk("clear_iss_ignored", 64'(bus_a.rd_busy[0]), 64'h0);

      // dual write to the same register: port A wins
      tick();
      bus_a.wa_en = 1'b1; bus_a.wa_addr = 5'd3; bus_a.wa_data = 32'h1111;
      bus_a.wb_en = 1'b1; bus_a.wb_addr = 5'd3; bus_a.wb_data = 32'h2222;
      rd_set_a(0, 5'd3);
      push(64'h1111);
      settle();
      pop_chk("dual_fwd", rd_a(0));
      tick();
      idle_a();
      push(64'h1111);
      settle();
      pop_chk("dual_array", rd_a(0));

      // x0 stays zero
      tick();
      bus_a.wa_en = 1'b1; bus_a.wa_addr = 5'd0; bus_a.wa_data = 32'hDEAD;
      rd_set_a(0, 5'd0);
      push(64'h0);
      settle();
      pop_chk("x0_fwd", rd_a(0));
      tick();
      idle_a();
      push(64'h0);
      settle();
      pop_chk("x0_array", rd_a(0));

      // port B forwarding on both read ports
      tick();
      bus_a.wb_en = 1'b1; bus_a.wb_addr = 5'd7; bus_a.wb_data = 32'hBEEF;
      rd_set_a(0, 5'd7);
      rd_set_a(1, 5'd7);
      push(64'hBEEF); push(64'hBEEF);
      settle();
      pop_chk("x7_fwd_p0", rd_a(0));
      pop_chk("x7_fwd_p1", rd_a(1));
      tick();
      idle_a();
      push(64'hBEEF); push(64'hBEEF);
      settle();
      pop_chk("x7_arr_p0", rd_a(0));
      pop_chk("x7_arr_p1", rd_a(1));

      // scoreboard
      tick();
      bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd4;
      rd_set_a(0, 5'd4);
      settle();
      chk("iss_same_cycle", 64'(bus_a.rd_busy[0]), 64'h0);
      tick();
      idle_a();
      settle();
      chk("iss_busy", 64'(bus_a.rd_busy[0]), 64'h1);
      bus_a.rd_en[0] = 1'b0;
      settle();
      chk("rden_mask_busy", 64'(bus_a.rd_busy[0]), 64'h0);
      bus_a.rd_en[0] = 1'b1;
      tick();
      bus_a.wa_en = 1'b1; bus_a.wa_addr = 5'd4; bus_a.wa_data = 32'h4444;
      push(64'h4444);
      settle();
      chk("wr_fwd_busy", 64'(bus_a.rd_busy[0]), 64'h0);
      pop_chk("wr_fwd_data", rd_a(0));
      tick();
      idle_a();
      push(64'h4444);
      settle();
      chk("busy_cleared", 64'(bus_a.rd_busy[0]), 64'h0);
      pop_chk("x4_array", rd_a(0));
      tick();
      bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd4;
      bus_a.wb_en = 1'b1; bus_a.wb_addr = 5'd4; bus_a.wb_data = 32'h5555;
      settle();
      tick();
      idle_a();
      push(64'h5555);
      settle();
      chk("set_wins", 64'(bus_a.rd_busy[0]), 64'h1);
      pop_chk("x4_new", rd_a(0));

      // mid-operation reset
      tick();
      bus_a.wa_en = 1'b1; bus_a.wa_addr = 5'd9; bus_a.wa_data = 32'h55;
      bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd9;
      rd_set_a(1, 5'd9);
      tick();
      idle_a();
      push(64'h55);
      settle();
      chk("x9_busy", 64'(bus_a.rd_busy[1]), 64'h1);
      pop_chk("x9_data", rd_a(1));
      rst_a = 1'b0;
      push(64'h0);
      settle();
      chk("midrst_init_done", 64'(bus_a.init_done), 64'h0);
      chk("midrst_busy", 64'(bus_a.rd_busy), 64'h0);
      pop_chk("midrst_rd", rd_a(1));
      tick();
      rst_a = 1'b1;
      for (int cyc = 1; cyc <= 32; cyc++) begin
         tick();
         settle();
         if (cyc >= 31)
            chk($sformatf("reclear_init_done_c%0d", cyc), 64'(bus_a.init_done), (cyc >= 32) ? 64'h1 : 64'h0);
      end
      push(64'h0);
      settle();
      pop_chk("x9_cleared", rd_a(1));
      chk("x9_busy_cleared", 64'(bus_a.rd_busy[1]), 64'h0);
      chk("x4_busy_cleared", 64'(bus_a.rd_busy[0]), 64'h0);

      // NREG=16, NRD=4, XLEN=64
      rst_b = 1'b1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         tick();
         settle();
         chk($sformatf("b_init_done_c%0d", cyc), 64'(bus_b.init_done), (cyc >= 16) ? 64'h1 : 64'h0);
      end
      tick();
      bus_b.wa_en = 1'b1; bus_b.wa_addr = 4'd1; bus_b.wa_data = vals[1];
      bus_b.wb_en = 1'b1; bus_b.wb_addr = 4'd2; bus_b.wb_data = vals[2];
      tick();
      bus_b.wa_addr = 4'd3; bus_b.wa_data = vals[3];
      bus_b.wb_addr = 4'd4; bus_b.wb_data = vals[4];
      tick();
      idle_b();
      for (int p = 0; p < 4; p++) begin
         rd_set_b(p, 4'(4 - p));
         push(vals[4 - p]);
      end
      settle();
      for (int p = 0; p < 4; p++) pop_chk($sformatf("b_rd_p%0d", p), rd_b(p));
      tick();
      bus_b.wa_en = 1'b1; bus_b.wa_addr = 4'd5; bus_b.wa_data = vals[5];
      rd_set_b(0, 4'd5); push(vals[5]);
      rd_set_b(1, 4'd1); push(vals[1]);
      rd_set_b(2, 4'd0); push(vals[0]);
      rd_set_b(3, 4'd5); push(vals[5]);
      settle();
      for (int p = 0; p < 4; p++) pop_chk($sformatf("b_fwd_p%0d", p), rd_b(p));
      tick();
      idle_b();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
